// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - scan-code constants, FSM encoding and key decode shared by the PS/2 move decoder
package ps2_pkg;

    localparam logic [7:0] SC_E0      = 8'hE0;
    localparam logic [7:0] SC_F0      = 8'hF0;
    localparam logic [7:0] SC_AR_UP   = 8'h75;
    localparam logic [7:0] SC_AR_DOWN = 8'h72;
    localparam logic [7:0] SC_AR_LEFT = 8'h6B;
    localparam logic [7:0] SC_AR_RGHT = 8'h74;
    localparam logic [7:0] SC_W       = 8'h1D;
    localparam logic [7:0] SC_S       = 8'h1B;
    localparam logic [7:0] SC_A       = 8'h1C;
    localparam logic [7:0] SC_D       = 8'h23;
    localparam logic [7:0] SC_Z       = 8'h1A;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_E0   = 2'd1;
    localparam logic [1:0] ST_F0   = 2'd2;
    localparam logic [1:0] ST_E0F0 = 2'd3;

    localparam int BTN_UP    = 3;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_RIGHT = 0;

    typedef enum logic [2:0] {
        KEY_NONE,
        KEY_UP,
        KEY_DOWN,
        KEY_LEFT,
        KEY_RIGHT,
        KEY_SHOOT
    } key_e;

    function automatic key_e decode_key(input logic [7:0] code, input logic ext);
        key_e k;
        k = KEY_NONE;
        if (ext) begin
            case (code)
                SC_AR_UP:   k = KEY_UP;
                SC_AR_DOWN: k = KEY_DOWN;
                SC_AR_LEFT: k = KEY_LEFT;
                SC_AR_RGHT: k = KEY_RIGHT;
                default:    k = KEY_NONE;
            endcase
        end else begin
            case (code)
                SC_W:    k = KEY_UP;
                SC_S:    k = KEY_DOWN;
                SC_A:    k = KEY_LEFT;
                SC_D:    k = KEY_RIGHT;
                SC_Z:    k = KEY_SHOOT;
                default: k = KEY_NONE;
            endcase
        end
        return k;
    endfunction

endpackage

// File: rtl/ps2_move_decoder_axis_resolve.sv
// rtl/ps2_move_decoder_axis_resolve.sv - collapses one axis' held pair into a 2-bit code, never 2'b11
module axis_resolve (
    input  logic       pos_act,
    input  logic       neg_act,
    input  logic       last_pos,
    output logic [1:0] axis
);

    always_comb begin
        axis = 2'b00;
        if (pos_act && neg_act)
            axis = last_pos ? 2'b10 : 2'b01;
        else if (pos_act)
            axis = 2'b10;
        else if (neg_act)
            axis = 2'b01;
    end

endmodule

// File: rtl/ps2_move_decoder.sv
// rtl/ps2_move_decoder.sv - PS/2 scan-code stream to movement vector and shoot level
module ps2_move_decoder
    import ps2_pkg::*;
#(
    parameter int PREFIX_TIMEOUT = 4
) (
    input  logic       clk22,
    input  logic       rst,
    input  logic       gameover,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic [3:0] btnstate,
    output logic       shoot,
    output logic       proto_err
);

    localparam int CW = $clog2(PREFIX_TIMEOUT + 1);

    logic [1:0]    state;
    logic [1:0]    nxt_state;
    logic [CW-1:0] tcnt;
    logic [3:0]    arrow;
    logic [3:0]    wasd;
    logic          shoot_held;
    logic          last_v;
    logic          last_h;

    logic          xfer;
    logic          act_make;
    logic          act_break;
    logic          act_ext;
    logic          byte_err;
    key_e          key;
    logic [1:0]    key_idx;
    logic          key_dir;
    logic          key_was_held;
    logic [1:0]    v_code;
    logic [1:0]    h_code;

    assign xfer = byte_valid && byte_ready;

    always_comb begin
        nxt_state = state;
        act_make  = 1'b0;
        act_break = 1'b0;
        act_ext   = 1'b0;
        byte_err  = 1'b0;
        if (xfer) begin
            case (state)
                ST_IDLE: begin
                    if (byte_data == SC_E0)
                        nxt_state = ST_E0;
                    else if (byte_data == SC_F0)
                        nxt_state = ST_F0;
                    else
                        act_make = 1'b1;
                end
                ST_E0: begin
                    if (byte_data == SC_F0) begin
                        nxt_state = ST_E0F0;
                    end else if (byte_data == SC_E0) begin
                        byte_err = 1'b1;
                    end else begin
                        act_make  = 1'b1;
                        act_ext   = 1'b1;
                        nxt_state = ST_IDLE;
                    end
                end
                default: begin
                    nxt_state = ST_IDLE;
                    if (byte_data == SC_E0 || byte_data == SC_F0) begin
                        byte_err = 1'b1;
                    end else begin
                        act_break = 1'b1;
                        act_ext   = (state == ST_E0F0);
                    end
                end
            endcase
        end
    end

    always_comb begin
        key          = decode_key(byte_data, act_ext);
        key_dir      = 1'b1;
        key_idx      = 2'(BTN_UP);
        case (key)
            KEY_UP:    key_idx = 2'(BTN_UP);
            KEY_DOWN:  key_idx = 2'(BTN_DOWN);
            KEY_LEFT:  key_idx = 2'(BTN_LEFT);
            KEY_RIGHT: key_idx = 2'(BTN_RIGHT);
            default:   key_dir = 1'b0;
        endcase
        key_was_held = act_ext ? arrow[key_idx] : wasd[key_idx];
    end

    axis_resolve u_axis_v (
        .pos_act (arrow[BTN_UP]   | wasd[BTN_UP]),
        .neg_act (arrow[BTN_DOWN] | wasd[BTN_DOWN]),
        .last_pos(last_v),
        .axis    (v_code)
    );

    axis_resolve u_axis_h (
        .pos_act (arrow[BTN_LEFT]  | wasd[BTN_LEFT]),
        .neg_act (arrow[BTN_RIGHT] | wasd[BTN_RIGHT]),
        .last_pos(last_h),
        .axis    (h_code)
    );

    always_ff @(posedge clk22) begin
        if (rst) begin
            byte_ready <= 1'b0;
            btnstate   <= 4'b0000;
            shoot      <= 1'b0;
            proto_err  <= 1'b0;
            state      <= ST_IDLE;
            tcnt       <= '0;
            arrow      <= 4'b0000;
            wasd       <= 4'b0000;
            shoot_held <= 1'b0;
            last_v     <= 1'b1;
            last_h     <= 1'b1;
        end else begin
            byte_ready <= 1'b1;
            proto_err  <= 1'b0;
            if (gameover) begin
                // Bytes keep draining while the game is over; they never touch held state.
                btnstate   <= 4'b0000;
                shoot      <= 1'b0;
                state      <= ST_IDLE;
                tcnt       <= '0;
                arrow      <= 4'b0000;
                wasd       <= 4'b0000;
                shoot_held <= 1'b0;
            end else begin
                btnstate <= {v_code, h_code};
                shoot    <= shoot_held;
                if (xfer) begin
                    tcnt      <= '0;
                    state     <= nxt_state;
                    proto_err <= byte_err;
                    if (act_make && key == KEY_SHOOT)
                        shoot_held <= 1'b1;
                    if (act_break && key == KEY_SHOOT)
                        shoot_held <= 1'b0;
                    if (act_make && key_dir) begin
                        if (act_ext)
                            arrow[key_idx] <= 1'b1;
                        else
                            wasd[key_idx] <= 1'b1;
                        // Only a fresh press claims priority; typematic repeats leave it alone.
                        if (!key_was_held) begin
                            if (key == KEY_UP)    last_v <= 1'b1;
                            if (key == KEY_DOWN)  last_v <= 1'b0;
                            if (key == KEY_LEFT)  last_h <= 1'b1;
                            if (key == KEY_RIGHT) last_h <= 1'b0;
                        end
                    end
                    if (act_break && key_dir) begin
                        if (act_ext)
                            arrow[key_idx] <= 1'b0;
                        else
                            wasd[key_idx] <= 1'b0;
                    end
                end else if (state != ST_IDLE) begin
                    if (tcnt == CW'(PREFIX_TIMEOUT - 1)) begin
                        state     <= ST_IDLE;
                        tcnt      <= '0;
                        proto_err <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end else begin
                    tcnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_move_decoder.sv
// tb/tb_ps2_move_decoder.sv - table-driven directed bench for ps2_move_decoder
module tb_ps2_move_decoder;

    logic       clk22 = 1'b0;
    logic       rst = 1'b1;
    logic       gameover = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_ready;
    logic [3:0] btnstate;
    logic       shoot;
    logic       proto_err;

    int vec_count = 0;
    int miss_count = 0;

    always #5 clk22 = ~clk22;

    ps2_move_decoder #(.PREFIX_TIMEOUT(4)) dut (
        .clk22     (clk22),
        .rst       (rst),
        .gameover  (gameover),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .btnstate  (btnstate),
        .shoot     (shoot),
        .proto_err (proto_err)
    );

    typedef struct {
        logic [7:0] b;
        logic [3:0] btn;
        logic       sht;
        logic       err;
    } vec_t;

    vec_t vecs [0:33];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk22);
        #1;
        rst = 1'b0;
    endtask

    // Returns #1 after the edge that accepted the byte.
    task automatic send_byte(input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        byte_data  = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk22);
            if (byte_ready) begin
                @(posedge clk22);
                #1;
                ok = 1'b1;
            end
        end
        byte_valid = 1'b0;
        if (!ok) begin
            miss_count++;
            vec_count++;
            $display("FAIL send_timeout: byte %h never accepted", b);
        end
    endtask

    task automatic tick();
        @(posedge clk22);
        #1;
    endtask

    initial begin
        int pulses;

        vecs[0]  = '{8'hE0, 4'b0000, 1'b0, 1'b0};
        vecs[1]  = '{8'h75, 4'b1000, 1'b0, 1'b0};
        vecs[2]  = '{8'hE0, 4'b1000, 1'b0, 1'b0};
        vecs[3]  = '{8'hF0, 4'b1000, 1'b0, 1'b0};
        vecs[4]  = '{8'h75, 4'b0000, 1'b0, 1'b0};
        vecs[5]  = '{8'hE0, 4'b0000, 1'b0, 1'b0};
        vecs[6]  = '{8'h75, 4'b1000, 1'b0, 1'b0};
        vecs[7]  = '{8'h1B, 4'b0100, 1'b0, 1'b0};
        vecs[8]  = '{8'hF0, 4'b0100, 1'b0, 1'b0};
        vecs[9]  = '{8'h1B, 4'b1000, 1'b0, 1'b0};
        vecs[10] = '{8'hE0, 4'b1000, 1'b0, 1'b0};
        vecs[11] = '{8'hF0, 4'b1000, 1'b0, 1'b0};
        vecs[12] = '{8'h75, 4'b0000, 1'b0, 1'b0};
        vecs[13] = '{8'h1C, 4'b0010, 1'b0, 1'b0};
        vecs[14] = '{8'hE0, 4'b0010, 1'b0, 1'b0};
        vecs[15] = '{8'h74, 4'b0001, 1'b0, 1'b0};
        vecs[16] = '{8'h1C, 4'b0001, 1'b0, 1'b0};
        vecs[17] = '{8'h1D, 4'b1001, 1'b0, 1'b0};
        vecs[18] = '{8'h1A, 4'b1001, 1'b1, 1'b0};
        vecs[19] = '{8'hF0, 4'b1001, 1'b1, 1'b0};
        vecs[20] = '{8'h1A, 4'b1001, 1'b0, 1'b0};
        vecs[21] = '{8'hF0, 4'b1001, 1'b0, 1'b0};
        vecs[22] = '{8'hF0, 4'b1001, 1'b0, 1'b1};
        vecs[23] = '{8'hE0, 4'b1001, 1'b0, 1'b0};
        vecs[24] = '{8'hE0, 4'b1001, 1'b0, 1'b1};
        vecs[25] = '{8'h6B, 4'b1010, 1'b0, 1'b0};
        vecs[26] = '{8'hAA, 4'b1010, 1'b0, 1'b0};
        vecs[27] = '{8'hF0, 4'b1010, 1'b0, 1'b0};
        vecs[28] = '{8'h23, 4'b1010, 1'b0, 1'b0};
        vecs[29] = '{8'hE0, 4'b1010, 1'b0, 1'b0};
        vecs[30] = '{8'hF0, 4'b1010, 1'b0, 1'b0};
        vecs[31] = '{8'h6B, 4'b1010, 1'b0, 1'b0};
        vecs[32] = '{8'hF0, 4'b1010, 1'b0, 1'b0};
        vecs[33] = '{8'h1C, 4'b1001, 1'b0, 1'b0};

        do_reset();
        chk("reset_ready", {7'b0, byte_ready}, 8'h00);
        chk("reset_btn", {4'b0, btnstate}, 8'h00);
        chk("reset_shoot", {7'b0, shoot}, 8'h00);
        chk("reset_err", {7'b0, proto_err}, 8'h00);
        tick();
        chk("ready_after_reset", {7'b0, byte_ready}, 8'h01);

        for (int i = 0; i < 34; i++) begin
            send_byte(vecs[i].b);
            chk($sformatf("v%0d_err", i), {7'b0, proto_err}, {7'b0, vecs[i].err});
            tick();
            chk($sformatf("v%0d_err_clear", i), {7'b0, proto_err}, 8'h00);
            chk($sformatf("v%0d_btn", i), {4'b0, btnstate}, {4'b0, vecs[i].btn});
            chk($sformatf("v%0d_shoot", i), {7'b0, shoot}, {7'b0, vecs[i].sht});
        end

        // Prefix timeout: abandoned E0 pulses proto_err once, then 75 is plain and unmapped.
        do_reset();
        send_byte(8'hE0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (proto_err) pulses++;
        end
        chk("timeout_pulses", 8'(pulses), 8'd1);
        send_byte(8'h75);
        chk("timeout_next_err", {7'b0, proto_err}, 8'h00);
        tick();
        chk("timeout_next_btn", {4'b0, btnstate}, 8'h00);

        // Gameover clears held movement and shoot; nothing returns once it falls.
        do_reset();
        send_byte(8'h1D);
        send_byte(8'h1A);
        tick();
        chk("go_pre_btn", {4'b0, btnstate}, 8'h08);
        chk("go_pre_shoot", {7'b0, shoot}, 8'h01);
        gameover = 1'b1;
        tick();
        gameover = 1'b0;
        chk("go_btn", {4'b0, btnstate}, 8'h00);
        chk("go_shoot", {7'b0, shoot}, 8'h00);
        tick();
        tick();
        tick();
        chk("go_after_btn", {4'b0, btnstate}, 8'h00);
        chk("go_after_shoot", {7'b0, shoot}, 8'h00);

        // Reset mid-sequence discards the E0 prefix.
        do_reset();
        send_byte(8'hE0);
        do_reset();
        send_byte(8'h75);
        tick();
        chk("rst_mid_btn", {4'b0, btnstate}, 8'h00);
        send_byte(8'hF0);
        chk("ff_first_err", {7'b0, proto_err}, 8'h00);
        send_byte(8'hF0);
        chk("ff_second_err", {7'b0, proto_err}, 8'h01);
        send_byte(8'h75);
        tick();
        chk("ff_idle_btn", {4'b0, btnstate}, 8'h00);
        send_byte(8'hE0);
        send_byte(8'h72);
        tick();
        chk("ff_down_btn", {4'b0, btnstate}, 8'h04);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/ps2_move_decoder.md
Name: ps2_move_decoder

Overview:
- Converts the PS/2 keyboard scan-code byte stream into the 4-bit `btnstate` movement vector consumed by the player-position block, plus a `shoot` level.
- Tracks make/break of arrow keys (extended) and WASD (plain); each direction is held if either of its keys is held.
- Resolves opposing directions by last-pressed-wins, so downstream never sees 2'b11 on an axis.
- Sits between the PS/2 byte receiver and the player/bullet logic, all on clk22.

Parameters:
- PREFIX_TIMEOUT, 4: clk22 cycles a prefix state (after E0/F0) may wait for its next byte before being abandoned.

Ports:
- clk22  in  1  game tick clock.
- rst  in  1  reset, synchronous, active-high.
- gameover  in  1  level; while high, all held-key state is cleared.
- byte_data  in  8  scan-code byte from PS/2 receiver.
- byte_valid  in  1  byte_data valid; held until accepted.
- byte_ready  out  1  block can accept; a transfer occurs on the clk22 edge where valid&&ready.
- btnstate  out  4  {up,down,left,right}: up 1000, down 0100, left 0010, right 0001; axes combine.
- shoot  out  1  Z key (0x1A) held.
- proto_err  out  1  one-cycle pulse on a malformed sequence.

Behaviour:
- Reset (rst=1 at edge): byte_ready=0, btnstate=0000, shoot=0, proto_err=0, FSM=IDLE, all held bits=0, last_v=UP, last_h=LEFT, timeout counter=0.
- byte_ready is a register: 0 in the cycle after reset, 1 thereafter. Bytes offered while ready=0 are not consumed.
- FSM states: IDLE, E0, F0, E0F0. At most one byte is consumed per edge.
  - IDLE: E0 goes to E0. F0 goes to F0. Any other byte is a plain make; stay in IDLE.
  - E0: F0 goes to E0F0. E0 gives proto_err, stay in E0. Any other byte is an extended make; go to IDLE.
  - F0: any byte other than E0/F0 is a plain break; go to IDLE. E0 or F0 gives proto_err and goes to IDLE.
  - E0F0: any byte other than E0/F0 is an extended break; go to IDLE. E0 or F0 gives proto_err and goes to IDLE.
- Timeout: in a prefix state, the counter increments on each edge with no transfer. When the counter reaches PREFIX_TIMEOUT, the FSM returns to IDLE with proto_err=1 and no key action. The counter clears on every transfer and in IDLE.
- Key map:
  - Extended: 75 up, 72 down, 6B left, 74 right.
  - Plain: 1D up, 1B down, 1C left, 23 right, 1A shoot.
  - Unmapped codes: the FSM advances normally, held bits are unchanged, no error.
  - Bytes AA, FA, EE, FE in IDLE are ignored.
- Held bits: arrow_{u,d,l,r} and wasd_{u,d,l,r}. up_act = arrow_u | wasd_u (likewise for the other directions).
- Priority:
  - A make of a vertical key whose held bit was 0 sets last_v to that direction. The same rule applies to last_h.
  - A typematic repeat (make while already held) does not change last_v/last_h.
- Axis output, vertical (horizontal identical with left/right, last_h):
  - up_act & down_act: last_v==UP gives 10, else 01.
  - Only up_act: 10. Only down_act: 01. Neither: 00.
- Latency:
  - Held bits and last_* update on the accepting edge N.
  - btnstate/shoot are registered from them and change after edge N+1 (one-cycle latency).
  - proto_err is asserted for the cycle after the detecting edge.
- gameover=1: every edge clears held bits, btnstate, and shoot, and forces FSM to IDLE. Bytes are still accepted (ready stays 1) and discarded. Held state resumes only from makes arriving after gameover falls.
- A break of a key not held is a no-op (no error).
- rst mid-sequence (e.g. after E0) discards the prefix; the next byte is parsed from IDLE.

Decomposition:
- Shared package `ps2_pkg`:
  - Scan-code constants (E0, F0, arrow/WASD/Z codes).
  - FSM state encoding.
  - btnstate bit positions (UP=3, DOWN=2, LEFT=1, RIGHT=0).
- Natural sub-module: `axis_resolve` (two held inputs + last flag → 2-bit axis code), instantiated twice.

Test Plan:
- Reset, then bytes E0,75 → btnstate=1000 one cycle after the 75 is accepted; then E0,F0,75 → 0000.
- Hold up (E0 75), then make 1B (S) → 0100; break 1B (F0 1B) → returns to 1000, since up is still held.
- Make 1C (A) and E0 74 (right), then repeat 1C → stays 0001 (repeat does not steal priority); then make 1D → 1001.
- E0 then no byte for 4 cycles → proto_err pulses once, FSM in IDLE; next 75 is treated as plain unmapped → btnstate unchanged.
- Hold W and Z (btnstate=1000, shoot=1), assert gameover 1 cycle → both cleared; deassert, send nothing → stays 0000/0.
- Send E0, assert rst, then send 75 → btnstate stays 0000; F0,F0 sequence → proto_err=1, FSM IDLE.
